// File: rtl/cpu_sequencer_pkg.sv
// rtl/cpu_sequencer_pkg.sv - shared widths, state encodings, trap causes and PC modes for the sequencer
package cpu_sequencer_pkg;

   localparam int XBUS        = 32;
   localparam int PC_MODE_MSB = 1;

   // Decoder pc_mode_if_taken encodings; only ADD is a relative branch
   localparam logic [PC_MODE_MSB:0] PC_MODE_NONE = 2'd0;
   localparam logic [PC_MODE_MSB:0] PC_MODE_ADD  = 2'd1;
   localparam logic [PC_MODE_MSB:0] PC_MODE_ABS  = 2'd2;

   typedef enum logic [1:0] {
      SEQ_ST_FETCH = 2'd0,
      SEQ_ST_EXEC  = 2'd1,
      SEQ_ST_ECALL = 2'd2,
      SEQ_ST_TRAP  = 2'd3
   } seq_state_e;

   localparam logic [1:0] TRAP_ILLEGAL  = 2'd0;
   localparam logic [1:0] TRAP_MISALIGN = 2'd1;

   // Sequential successor of a word-aligned PC, modulo 2^32
   function automatic logic [XBUS-1:0] pc_next_seq(input logic [XBUS-1:0] pc_val);
      return pc_val + 32'd4;
   endfunction

endpackage

// File: rtl/cpu_sequencer_seq_counters.sv
// rtl/cpu_sequencer_seq_counters.sv - free-running cycle and retired-instruction counters
module seq_counters
   import cpu_sequencer_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            retire_i,
   output logic [XBUS-1:0] cycle_cnt_o,
   output logic [XBUS-1:0] instret_cnt_o
);

   logic [XBUS-1:0] cycle_q, cycle_d;
   logic [XBUS-1:0] instret_q, instret_d;

   // Next counts; both wrap naturally at 2^32
   always_comb begin
      cycle_d   = cycle_q + 32'd1;
      instret_d = instret_q;
      if (retire_i) instret_d = instret_q + 32'd1;
   end

   // Counter registers, cleared by reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         cycle_q   <= cycle_d;
         instret_q <= instret_d;
      end
   end

   assign cycle_cnt_o   = cycle_q;
   assign instret_cnt_o = instret_q;

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - fetch/exec/ecall/trap control FSM owning PC and halt state (SEQ_COUNTERS_EN adds counters)
module cpu_sequencer
   import cpu_sequencer_pkg::*;
#(
   parameter logic [XBUS-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 imem_req,
   output logic [XBUS-1:0]      imem_addr,
   input  logic                 imem_ack,
   input  logic [XBUS-1:0]      imem_data,
   output logic [XBUS-1:0]      inst,
   input  logic                 dec_exc,
   input  logic                 dec_act_write_reg,
   input  logic                 dec_act_ecall,
   input  logic                 dec_is_cond,
   input  logic [XBUS-1:0]      dec_pc_update,
   input  logic [PC_MODE_MSB:0] dec_pc_mode,
   input  logic                 alu_cond,
   output logic                 reg_we,
   output logic                 ecall_req,
   input  logic                 ecall_ack,
   output logic [XBUS-1:0]      pc,
   output logic                 retire,
   output logic                 halted,
   output logic [1:0]           trap_cause,
   output logic [XBUS-1:0]      trap_pc
`ifdef SEQ_COUNTERS_EN
   ,
   output logic [XBUS-1:0]      cycle_cnt,
   output logic [XBUS-1:0]      instret_cnt
`endif
);

   seq_state_e      state_q, state_d;
   logic [XBUS-1:0] pc_q, pc_d;
   logic [XBUS-1:0] inst_q, inst_d;
   logic            halted_q, halted_d;
   logic [1:0]      cause_q, cause_d;
   logic [XBUS-1:0] trap_pc_q, trap_pc_d;

   logic            imem_req_c, reg_we_c, retire_c, ecall_req_c;
   logic            taken;
   logic [XBUS-1:0] target;

   assign taken  = dec_is_cond && alu_cond && (dec_pc_mode == PC_MODE_ADD);
   assign target = pc_q + dec_pc_update;

   // Next-state and Moore-plus-decode outputs; EXEC resolves actions in priority order
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      inst_d      = inst_q;
      halted_d    = halted_q;
      cause_d     = cause_q;
      trap_pc_d   = trap_pc_q;
      imem_req_c  = 1'b0;
      reg_we_c    = 1'b0;
      retire_c    = 1'b0;
      ecall_req_c = 1'b0;
      case (state_q)
         SEQ_ST_FETCH: begin
            imem_req_c = 1'b1;
            if (imem_ack) begin
               inst_d  = imem_data;
               state_d = SEQ_ST_EXEC;
            end
         end
         SEQ_ST_EXEC: begin
            if (dec_exc) begin
               state_d   = SEQ_ST_TRAP;
               cause_d   = TRAP_ILLEGAL;
               halted_d  = 1'b1;
               trap_pc_d = pc_q;
            end else if (dec_act_ecall) begin
               state_d = SEQ_ST_ECALL;
            end else if (taken && target[1]) begin
               state_d   = SEQ_ST_TRAP;
               cause_d   = TRAP_MISALIGN;
               halted_d  = 1'b1;
               trap_pc_d = pc_q;
            end else begin
               reg_we_c = dec_act_write_reg;
               retire_c = 1'b1;
               pc_d     = taken ? target : pc_next_seq(pc_q);
               state_d  = SEQ_ST_FETCH;
            end
         end
         SEQ_ST_ECALL: begin
            ecall_req_c = 1'b1;
            if (ecall_ack) begin
               pc_d     = pc_next_seq(pc_q);
               retire_c = 1'b1;
               state_d  = SEQ_ST_FETCH;
            end
         end
         SEQ_ST_TRAP: begin
            state_d = SEQ_ST_TRAP;
         end
         default: state_d = SEQ_ST_FETCH;
      endcase
   end

   // State and architectural registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= SEQ_ST_FETCH;
         pc_q      <= RESET_PC;
         inst_q    <= '0;
         halted_q  <= 1'b0;
         cause_q   <= TRAP_ILLEGAL;
         trap_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         halted_q  <= halted_d;
         cause_q   <= cause_d;
         trap_pc_q <= trap_pc_d;
      end
   end

   // Requests and pulses are suppressed in the same cycle reset is asserted
   assign imem_req   = imem_req_c  & ~rst;
   assign reg_we     = reg_we_c    & ~rst;
   assign retire     = retire_c    & ~rst;
   assign ecall_req  = ecall_req_c & ~rst;
   assign imem_addr  = pc_q;
   assign pc         = pc_q;
   assign inst       = inst_q;
   assign halted     = halted_q;
   assign trap_cause = cause_q;
   assign trap_pc    = trap_pc_q;

`ifdef SEQ_COUNTERS_EN
   seq_counters u_counters (
      .clk_i         (clk),
      .rst_i         (rst),
      .retire_i      (retire),
      .cycle_cnt_o   (cycle_cnt),
      .instret_cnt_o (instret_cnt)
   );
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - scoreboard bench for cpu_sequencer fetch, branch, trap, ecall and reset behaviour
module tb_cpu_sequencer;
   import cpu_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req, imem_ack = 1'b0;
   logic [31:0] imem_addr, imem_data = 32'h0;
   logic [31:0] inst;
   logic        dec_exc = 0, dec_act_write_reg = 0, dec_act_ecall = 0, dec_is_cond = 0;
   logic [31:0] dec_pc_update = 32'h0;
   logic [PC_MODE_MSB:0] dec_pc_mode = PC_MODE_NONE;
   logic        alu_cond = 0;
   logic        reg_we, ecall_req, ecall_ack = 1'b0;
   logic [31:0] pc;
   logic        retire, halted;
   logic [1:0]  trap_cause;
   logic [31:0] trap_pc;
`ifdef SEQ_COUNTERS_EN
   logic [31:0] cycle_cnt, instret_cnt;
`endif

   cpu_sequencer #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_data(imem_data), .inst(inst), .dec_exc(dec_exc), .dec_act_write_reg(dec_act_write_reg),
      .dec_act_ecall(dec_act_ecall), .dec_is_cond(dec_is_cond), .dec_pc_update(dec_pc_update),
      .dec_pc_mode(dec_pc_mode), .alu_cond(alu_cond), .reg_we(reg_we), .ecall_req(ecall_req),
      .ecall_ack(ecall_ack), .pc(pc), .retire(retire), .halted(halted), .trap_cause(trap_cause),
      .trap_pc(trap_pc)
`ifdef SEQ_COUNTERS_EN
      , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] pc_next; logic we; } exp_t;
   exp_t sb[$];

   typedef struct { logic [31:0] word; logic wr; logic cond; logic acond;
                    logic [31:0] off; logic [1:0] mode; int delay; } ins_t;

   int checks = 0;
   int failures = 0;

   task automatic set_dec(input logic exc, input logic wr, input logic ecall, input logic cond,
                          input logic acond, input logic [31:0] off, input logic [1:0] mode);
      dec_exc = exc; dec_act_write_reg = wr; dec_act_ecall = ecall; dec_is_cond = cond;
      alu_cond = acond; dec_pc_update = off; dec_pc_mode = mode;
   endtask

   // Reset for one edge, release at a negedge; leaves the DUT in FETCH
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; imem_ack = 1'b0; ecall_ack = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Entered at a negedge in FETCH; returns at the negedge of the EXEC cycle
   task automatic fetch(input logic [31:0] word, input int delay, output bit stable);
      logic [31:0] a0;
      #1;
      a0 = imem_addr;
      stable = 1'b1;
      for (int i = 0; i < delay; i++) begin
         if (imem_req !== 1'b1 || imem_addr !== a0) stable = 1'b0;
         @(negedge clk);
         #1;
      end
      if (imem_req !== 1'b1 || imem_addr !== a0) stable = 1'b0;
      imem_data = word; imem_ack = 1'b1;
      @(posedge clk);
      #1 imem_ack = 1'b0; imem_data = 32'hDEAD_BEEF;
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
      checks++; if (inst !== 32'h0) begin failures++; $display("FAIL reset_inst got=%h exp=0", inst); end
      checks++; if ({halted, trap_cause, trap_pc} !== 35'h0) begin failures++;
         $display("FAIL reset_trap got=%b/%0d/%h exp=0/0/0", halted, trap_cause, trap_pc); end
      checks++; if ({imem_req, reg_we, retire, ecall_req} !== 4'b0) begin failures++;
         $display("FAIL reset_outputs got=%b exp=0000", {imem_req, reg_we, retire, ecall_req}); end
      rst = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL reset_release_req got=%b exp=1", imem_req); end
`ifdef SEQ_COUNTERS_EN
      checks++; if (cycle_cnt !== 32'd0) begin failures++; $display("FAIL reset_cycle_cnt got=%0d exp=0", cycle_cnt); end
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (cycle_cnt !== 32'd3) begin failures++; $display("FAIL cycle_cnt got=%0d exp=3", cycle_cnt); end
`endif
   endtask

   task automatic test_addi();
      bit st; exp_t e;
      do_reset();
      set_dec(0, 1, 0, 0, 0, 32'd0, PC_MODE_NONE);
      sb.push_back('{pc_next: 32'd4, we: 1'b1});
      fetch(32'h0050_0093, 0, st);
      checks++; if (inst !== 32'h0050_0093) begin failures++; $display("FAIL addi_inst got=%h exp=00500093", inst); end
      checks++; if (retire !== 1'b1) begin failures++; $display("FAIL addi_retire got=%b exp=1", retire); end
      e = sb.pop_front();
      checks++; if (reg_we !== e.we) begin failures++; $display("FAIL addi_reg_we got=%b exp=%b", reg_we, e.we); end
      @(posedge clk); @(negedge clk);
      checks++; if (pc !== e.pc_next) begin failures++; $display("FAIL addi_pc got=%h exp=%h", pc, e.pc_next); end
      checks++; if ({reg_we, retire} !== 2'b00) begin failures++; $display("FAIL addi_pulse_len got=%b exp=00", {reg_we, retire}); end
   endtask

   task automatic test_branch_delayed();
      bit st; exp_t e;
      do_reset();
      set_dec(0, 0, 0, 1, 1, 32'd8, PC_MODE_ADD);
      sb.push_back('{pc_next: 32'd8, we: 1'b0});
      fetch(32'h0000_0463, 3, st);
      checks++; if (st !== 1'b1) begin failures++; $display("FAIL beq_addr_stable got=%b exp=1", st); end
      checks++; if (retire !== 1'b1) begin failures++; $display("FAIL beq_retire got=%b exp=1", retire); end
      e = sb.pop_front();
      checks++; if (reg_we !== e.we) begin failures++; $display("FAIL beq_reg_we got=%b exp=%b", reg_we, e.we); end
      @(posedge clk); @(negedge clk);
      checks++; if (pc !== e.pc_next) begin failures++; $display("FAIL beq_pc got=%h exp=%h", pc, e.pc_next); end
   endtask

   task automatic test_misalign();
      bit st; int reqs;
      do_reset();
      set_dec(0, 0, 0, 1, 1, 32'd6, PC_MODE_ADD);
      fetch(32'h0000_0363, 0, st);
      checks++; if ({retire, reg_we} !== 2'b00) begin failures++; $display("FAIL mis_no_retire got=%b exp=00", {retire, reg_we}); end
      @(posedge clk); @(negedge clk);
      checks++; if (halted !== 1'b1 || trap_cause !== TRAP_MISALIGN) begin failures++;
         $display("FAIL mis_trap got=%b/%0d exp=1/1", halted, trap_cause); end
      checks++; if (trap_pc !== 32'h0) begin failures++; $display("FAIL mis_trap_pc got=%h exp=0", trap_pc); end
      reqs = 0;
      for (int i = 0; i < 4; i++) begin
         if (imem_req !== 1'b0) reqs++;
         @(negedge clk);
      end
      checks++; if (reqs != 0 || pc !== 32'h0) begin failures++; $display("FAIL mis_frozen got=req%0d/pc%h exp=req0/pc0", reqs, pc); end
   endtask

   task automatic test_illegal();
      bit st;
      do_reset();
      set_dec(0, 1, 0, 0, 0, 32'd0, PC_MODE_NONE);
      fetch(32'h0050_0093, 0, st);
      @(posedge clk); @(negedge clk);
      set_dec(1, 0, 0, 0, 0, 32'd0, PC_MODE_NONE);
      fetch(32'hFFFF_FFFF, 0, st);
      checks++; if (retire !== 1'b0) begin failures++; $display("FAIL ill_no_retire got=%b exp=0", retire); end
      @(posedge clk); @(negedge clk);
      checks++; if (halted !== 1'b1 || trap_cause !== TRAP_ILLEGAL) begin failures++;
         $display("FAIL ill_trap got=%b/%0d exp=1/0", halted, trap_cause); end
      checks++; if (trap_pc !== 32'h4 || pc !== 32'h4) begin failures++;
         $display("FAIL ill_trap_pc got=%h/%h exp=4/4", trap_pc, pc); end
      for (int i = 0; i < 3; i++) begin
         imem_data = 32'h0000_0013; imem_ack = 1'b1;
         @(posedge clk); @(negedge clk);
      end
      imem_ack = 1'b0;
      checks++; if (inst !== 32'hFFFF_FFFF || halted !== 1'b1 || imem_req !== 1'b0) begin failures++;
         $display("FAIL ill_ack_ignored got=%h/%b/%b exp=ffffffff/1/0", inst, halted, imem_req); end
      set_dec(0, 0, 0, 0, 0, 32'd0, PC_MODE_NONE);
      do_reset();
      #1;
      checks++; if (pc !== 32'h0 || halted !== 1'b0 || trap_pc !== 32'h0 || imem_req !== 1'b1) begin failures++;
         $display("FAIL ill_reset_clear got=%h/%b/%h/%b exp=0/0/0/1", pc, halted, trap_pc, imem_req); end
   endtask

   task automatic test_ecall();
      bit st; exp_t e; int held; logic [31:0] i0;
      do_reset();
      set_dec(0, 1, 1, 0, 0, 32'd0, PC_MODE_NONE);
      sb.push_back('{pc_next: 32'd4, we: 1'b0});
      fetch(32'h0000_0073, 0, st);
      checks++; if ({retire, reg_we, ecall_req} !== 3'b000) begin failures++;
         $display("FAIL ecall_exec got=%b exp=000", {retire, reg_we, ecall_req}); end
      i0 = inst;
      held = 0;
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (ecall_req === 1'b1 && retire === 1'b0) held++;
         imem_ack = (i == 1); imem_data = 32'h0000_0013;
      end
      @(negedge clk);
      imem_ack = 1'b0;
      if (ecall_req === 1'b1) held++;
      ecall_ack = 1'b1;
      #1;
      e = sb.pop_front();
      checks++; if (retire !== 1'b1 || reg_we !== e.we) begin failures++;
         $display("FAIL ecall_retire got=%b/%b exp=1/%b", retire, reg_we, e.we); end
      checks++; if (held != 5) begin failures++; $display("FAIL ecall_req_cycles got=%0d exp=5", held); end
      checks++; if (inst !== i0) begin failures++; $display("FAIL ecall_imem_ack_ignored got=%h exp=%h", inst, i0); end
      @(posedge clk);
      #1 ecall_ack = 1'b0;
      @(negedge clk);
      checks++; if (pc !== e.pc_next || imem_req !== 1'b1) begin failures++;
         $display("FAIL ecall_pc got=%h/%b exp=%h/1", pc, imem_req, e.pc_next); end
`ifdef SEQ_COUNTERS_EN
      checks++; if (instret_cnt !== 32'd1) begin failures++; $display("FAIL ecall_instret got=%0d exp=1", instret_cnt); end
`endif
   endtask

   task automatic test_reset_in_ecall();
      bit st;
      do_reset();
      set_dec(0, 0, 1, 0, 0, 32'd0, PC_MODE_NONE);
      fetch(32'h0000_0073, 0, st);
      @(posedge clk);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (ecall_req !== 1'b0) begin failures++; $display("FAIL rst_ecall_req got=%b exp=0", ecall_req); end
      @(posedge clk); @(negedge clk);
      checks++; if (pc !== 32'h0 || ecall_req !== 1'b0 || imem_req !== 1'b0) begin failures++;
         $display("FAIL rst_ecall_state got=%h/%b/%b exp=0/0/0", pc, ecall_req, imem_req); end
`ifdef SEQ_COUNTERS_EN
      checks++; if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin failures++;
         $display("FAIL rst_ecall_counters got=%0d/%0d exp=0/0", cycle_cnt, instret_cnt); end
`endif
      rst = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rst_ecall_resume got=%b exp=1", imem_req); end
      set_dec(0, 0, 0, 0, 0, 32'd0, PC_MODE_NONE);
   endtask

   task automatic test_back_to_back();
      ins_t prog [5] = '{
         '{32'hFE00_0EE3, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, PC_MODE_ADD,  0},
         '{32'h0050_0093, 1'b1, 1'b0, 1'b0, 32'h0,         PC_MODE_NONE, 1},
         '{32'h0010_0113, 1'b1, 1'b0, 1'b0, 32'h0,         PC_MODE_NONE, 0},
         '{32'h0000_006F, 1'b0, 1'b0, 1'b1, 32'h0000_0040, PC_MODE_ADD,  2},
         '{32'h0020_8463, 1'b0, 1'b1, 1'b1, 32'h0000_0040, PC_MODE_ABS,  0}
      };
      logic [31:0] mpc; logic tk; bit st; exp_t e;
      do_reset();
      ecall_ack = 1'b1;
      mpc = 32'h0;
      foreach (prog[k]) begin
         tk = prog[k].cond && prog[k].acond && (prog[k].mode == PC_MODE_ADD);
         set_dec(0, prog[k].wr, 0, prog[k].cond, prog[k].acond, prog[k].off, prog[k].mode);
         sb.push_back('{pc_next: tk ? mpc + prog[k].off : mpc + 32'd4, we: prog[k].wr});
         fetch(prog[k].word, prog[k].delay, st);
         e = sb.pop_front();
         checks++; if (retire !== 1'b1 || reg_we !== e.we) begin failures++;
            $display("FAIL b2b_commit[%0d] got=%b/%b exp=1/%b", k, retire, reg_we, e.we); end
         @(posedge clk); @(negedge clk);
         checks++; if (pc !== e.pc_next) begin failures++; $display("FAIL b2b_pc[%0d] got=%h exp=%h", k, pc, e.pc_next); end
         mpc = e.pc_next;
      end
      ecall_ack = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_addi();
      test_branch_delayed();
      test_misalign();
      test_illegal();
      test_ecall();
      test_reset_in_ecall();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
